// File: rtl/freq_div_scheduler.sv
// freq_div_scheduler
// Run/stop and ratio-reconfiguration controller for an integer clock divider.
// It produces a divided clock level and a period-start tick from clk_in. New
// divide ratios are accepted over a valid/ready handshake. Each new ratio takes
// effect only at a period boundary, so the output period never glitches.
//
// Ports:
//   clk_in      system clock
//   rst         synchronous, active-high reset
//   en_req      level: 1 = run the divider, 0 = stop at the next period boundary
//   cfg_valid   a new ratio is offered on cfg_div
//   cfg_div     requested ratio N (CNT_W bits)
//   cfg_ready   the controller can accept a ratio (the pending slot is empty)
//   div_out     divided clock level: high for ceil(N/2) cycles, low for floor(N/2)
//   tick        one-cycle pulse on the first cycle of each output period
//   busy        1 while the divider is running
//   active_div  ratio currently in force
//   cfg_err     one-cycle pulse after a ratio below 2 was offered and rejected
module freq_div_scheduler #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 7
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en_req,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             div_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] active_div,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_t;

  localparam logic [CNT_W-1:0] DEF_RATIO = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] pend_div, pend_div_n;
  logic             pend_valid, pend_valid_n;
  logic [CNT_W-1:0] active_div_n;
  logic             div_out_n, tick_n, busy_n, cfg_ready_n, cfg_err_n;

  logic             accept, ratio_ok;
  logic             boundary;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] high_len;

  assign accept   = cfg_valid & cfg_ready;
  assign ratio_ok = accept & (cfg_div >= TWO);
  assign boundary = (state == RUN) && (cnt == active_div - ONE);
  assign cnt_inc  = cnt + ONE;
  // The high phase is N - floor(N/2), which is ceil(N/2). Computing it this way
  // stays inside CNT_W bits even when N is the largest representable value.
  assign high_len = active_div - (active_div >> 1);

  // This block registers the state and all outputs. Because every output is
  // a flop, div_out and tick stay aligned with cnt and do not glitch.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      div_out    <= 1'b0;
      tick       <= 1'b0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
      active_div <= DEF_RATIO;
      pend_valid <= 1'b0;
      pend_div   <= '0;
      cfg_ready  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      div_out    <= div_out_n;
      tick       <= tick_n;
      busy       <= busy_n;
      cfg_err    <= cfg_err_n;
      active_div <= active_div_n;
      pend_valid <= pend_valid_n;
      pend_div   <= pend_div_n;
      cfg_ready  <= cfg_ready_n;
    end
  end

  // This block computes the next state and next output values.
  // The defaults describe a stopped divider. Ratio changes are decided here
  // so that they can only land where a new period begins.
  always_comb begin
    state_n      = IDLE;
    cnt_n        = '0;
    div_out_n    = 1'b0;
    tick_n       = 1'b0;
    busy_n       = 1'b0;
    active_div_n = active_div;
    pend_valid_n = pend_valid;
    pend_div_n   = pend_div;
    cfg_err_n    = accept & ~ratio_ok;

    case (state)
      IDLE: begin
        // While stopped there is no period to protect, so a good ratio
        // takes effect right away.
        if (ratio_ok) begin
          active_div_n = cfg_div;
        end
        if (en_req) begin
          state_n   = RUN;
          div_out_n = 1'b1;
          tick_n    = 1'b1;
          busy_n    = 1'b1;
        end
      end

      RUN: begin
        if (boundary) begin
          // A ratio in the pending slot was queued earlier, so it wins.
          // The slot is full only when cfg_ready is low, so it cannot
          // collide with a ratio that is accepted on this same edge.
          pend_valid_n = 1'b0;
          if (pend_valid) begin
            active_div_n = pend_div;
          end else if (ratio_ok) begin
            active_div_n = cfg_div;
          end
          if (en_req) begin
            state_n   = RUN;
            div_out_n = 1'b1;
            tick_n    = 1'b1;
            busy_n    = 1'b1;
          end
        end else begin
          state_n   = RUN;
          busy_n    = 1'b1;
          cnt_n     = cnt_inc;
          div_out_n = (cnt_inc < high_len);
          if (ratio_ok) begin
            pend_valid_n = 1'b1;
            pend_div_n   = cfg_div;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    cfg_ready_n = ~pend_valid_n;
  end

endmodule

// File: tb/tb_freq_div_scheduler.sv
// tb_freq_div_scheduler
// Scoreboard bench for freq_div_scheduler. The stimulus side drives inputs and
// steps a period-level reference model. The model tracks the position inside
// the current period, the ratio in force, and a queue of deferred ratios. For
// each edge it pushes the expected outputs. A separate monitor pops one entry
// per cycle and compares it against the DUT.
module tb_freq_div_scheduler;

  localparam int CNT_W = 8;
  localparam int DEF   = 7;

  logic             clk_in = 1'b0;
  logic             rst, en_req, cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready, div_out, tick, busy, cfg_err;
  logic [CNT_W-1:0] active_div;

  typedef struct {
    bit busy;
    bit tick;
    bit div;
    int active;
    bit ready;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   pend_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_run   = 1'b0;
  int m_pos   = 0;
  int m_n     = DEF;
  bit m_ready = 1'b0;

  bit stim_done = 1'b0;

  freq_div_scheduler #(.CNT_W(CNT_W), .DEF_DIV(DEF)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en_req    (en_req),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .div_out   (div_out),
    .tick      (tick),
    .busy      (busy),
    .active_div(active_div),
    .cfg_err   (cfg_err)
  );

  always #5 clk_in = ~clk_in;

  // One step of the model gives the outputs expected right after the next edge.
  task automatic modelStep(input bit r, input bit e, input bit v, input int d);
    exp_t x;
    bit   acc;
    bit   okr;
    x.err = 1'b0;
    if (r) begin
      m_run   = 1'b0;
      m_pos   = 0;
      m_n     = DEF;
      m_ready = 1'b0;
      pend_q.delete();
    end else begin
      acc   = v && m_ready;
      okr   = acc && (d >= 2);
      x.err = acc && !okr;
      if (!m_run) begin
        if (okr) m_n = d;
        if (e) begin
          m_run = 1'b1;
          m_pos = 0;
        end
      end else if (m_pos == m_n - 1) begin
        if (pend_q.size() > 0) m_n = pend_q.pop_front();
        else if (okr) m_n = d;
        m_run = e;
        m_pos = 0;
      end else begin
        m_pos++;
        if (okr) pend_q.push_back(d);
      end
      m_ready = (pend_q.size() == 0);
    end
    x.busy   = m_run;
    x.tick   = m_run && (m_pos == 0);
    x.div    = m_run && (m_pos < (m_n + 1) / 2);
    x.active = m_n;
    x.ready  = m_ready;
    exp_q.push_back(x);
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit v, input int d);
    rst       = r;
    en_req    = e;
    cfg_valid = v;
    cfg_div   = CNT_W'(d);
    modelStep(r, e, v, d);
    @(posedge clk_in);
    #1;
  endtask

  task automatic repeatStimulus(input int n, input bit r, input bit e);
    for (int i = 0; i < n; i++) applyStimulus(r, e, 1'b0, 0);
  endtask

  task automatic checkOutput(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d want=%0d at t=%0t", name, got, want, $time);
    end
  endtask

  // The monitor samples 2 time units after each active edge and checks every
  // output against the oldest pending expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk_in);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checkOutput("busy",       int'(busy),       int'(x.busy));
        checkOutput("tick",       int'(tick),       int'(x.tick));
        checkOutput("div_out",    int'(div_out),    int'(x.div));
        checkOutput("active_div", int'(active_div), x.active);
        checkOutput("cfg_ready",  int'(cfg_ready),  int'(x.ready));
        checkOutput("cfg_err",    int'(cfg_err),    int'(x.err));
      end
    end
  end

  initial begin
    bit cur_en;
    bit cur_v;
    int cur_d;
    bit r;
    rst = 1'b1; en_req = 1'b0; cfg_valid = 1'b0; cfg_div = '0;

    // Directed scenarios
    repeatStimulus(3, 1'b1, 1'b0);
    repeatStimulus(1, 1'b0, 1'b0);
    repeatStimulus(3, 1'b0, 1'b1);               // start, N=7
    applyStimulus(1'b0, 1'b1, 1'b1, 4);          // defer ratio 4
    repeatStimulus(14, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);          // rejected in RUN
    applyStimulus(1'b0, 1'b1, 1'b1, 0);
    repeatStimulus(10, 1'b0, 1'b0);              // stop at boundary
    applyStimulus(1'b0, 1'b0, 1'b1, 0);          // rejected in IDLE
    applyStimulus(1'b0, 1'b0, 1'b1, 5);          // immediate in IDLE
    repeatStimulus(2, 1'b0, 1'b1);
    repeatStimulus(2, 1'b0, 1'b0);               // drop then re-raise
    repeatStimulus(15, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 3);          // pending + stop
    repeatStimulus(12, 1'b0, 1'b0);
    repeatStimulus(8, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2);          // N=2 pending
    repeatStimulus(8, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 6);
    repeatStimulus(1, 1'b1, 1'b1);               // reset drops pending
    repeatStimulus(14, 1'b0, 1'b1);

    // Randomized traffic
    cur_en = 1'b1;
    cur_v  = 1'b0;
    cur_d  = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) cur_en = ~cur_en;
      if (!(cur_v && !m_ready)) begin
        cur_v = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 9) == 0) cur_d = $urandom_range(0, 1);
        else cur_d = $urandom_range(2, 12);
      end
      applyStimulus(r, cur_en, cur_v, cur_d);
    end
    repeatStimulus(1, 1'b0, 1'b0);
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    repeat (3) @(posedge clk_in);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got=%0d leftover want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got=running want=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/freq_div_scheduler.md
Name: freq_div_scheduler

Overview:
Run/stop and ratio-reconfiguration controller for the integer clock-divider datapath.
- Generates a divided clock level (div_out) and a period-start tick from clk_in.
- Accepts new divide ratios through a valid/ready handshake and applies each one only at a period boundary, so the output period changes without glitches.
- Sits between the register/config logic and the consumers of the divided clock/enable.

Parameters:
CNT_W, 8, width of divide ratio and internal counter
DEF_DIV, 7, ratio loaded at reset; must be >= 2 and <= 2^CNT_W-1

Ports:
clk_in  input  1  system clock
rst  input  1  synchronous, active-high reset
en_req  input  1  level: 1 = run divider, 0 = stop at next period boundary
cfg_valid  input  1  new ratio offered
cfg_div  input  CNT_W  requested ratio N
cfg_ready  output  1  controller can accept a ratio
div_out  output  1  divided clock level
tick  output  1  one-cycle pulse on first cycle of each output period
busy  output  1  1 while in RUN
active_div  output  CNT_W  ratio currently in force
cfg_err  output  1  one-cycle pulse: rejected ratio (cfg_div < 2)

Behaviour:
- All outputs are registered. Reset is clocked on clk_in while rst=1. Reset values:
  - state=IDLE, cnt=0, div_out=0, tick=0, busy=0, cfg_err=0.
  - active_div=DEF_DIV, pending slot empty, cfg_ready=0.
  - cfg_ready goes to 1 on the first edge with rst=0.
- Reset mid-operation: everything returns to reset values on the next edge; a pending ratio is discarded.
- States:
  - IDLE: cnt=0, div_out=0, tick=0, busy=0.
  - RUN: cnt counts 0..N-1 and wraps, where N = active_div.
- Output timing in RUN:
  - div_out = 1 when cnt < H, with H = N - floor(N/2). So div_out is high for ceil(N/2) cycles and low for floor(N/2) cycles.
  - tick = 1 when cnt == 0.
  - Both are aligned with cnt, not delayed.
- IDLE -> RUN: en_req=1 sampled at edge t. From cycle t+1: busy=1, cnt=0, div_out=1, tick=1. Start latency is 1 cycle.
- RUN -> IDLE:
  - The transition happens only at the boundary, i.e. the edge where cnt==N-1 with en_req=0. The next cycle has div_out=0, busy=0.
  - Deasserting en_req mid-period does not truncate the period.
  - If en_req returns to 1 before the boundary, RUN continues with no gap.
- Handshake:
  - Transfer occurs when cfg_valid & cfg_ready at an edge.
  - cfg_ready = 1 exactly when the pending slot is empty and not in reset.
  - cfg_div must be held stable while cfg_valid=1 and cfg_ready=0.
- Invalid ratio (cfg_div < 2):
  - The transfer completes (ready stays 1).
  - cfg_err=1 for the following cycle.
  - active_div and the pending slot are unchanged.
- Valid ratio accepted in IDLE: active_div takes the new value the next cycle. The pending slot is not used.
- Valid ratio accepted in RUN, not on a boundary edge:
  - The value is stored in the pending slot and cfg_ready drops to 0 the next cycle.
  - At the next boundary edge (cnt==N-1): active_div takes the pending value, cnt goes to 0, and the new period starts with tick=1.
  - The slot clears and cfg_ready=1 on that same next cycle.
- Valid ratio accepted on a boundary edge in RUN: it applies directly to the period starting on the next cycle, without using the slot.
- Boundary with en_req=0 and a pending ratio: the ratio is applied (active_div updated) and the state goes to IDLE.
- Width rules:
  - cnt is CNT_W bits and compares against active_div-1.
  - H is computed in CNT_W bits; no overflow for N <= 2^CNT_W-1.
- N=2: div_out alternates 1,0 and tick occurs every 2nd cycle.
- No other state exists; unreachable encodings return to IDLE.

Test Plan:
- Reset then en_req=1 at edge t, DEF_DIV=7 -> t+1: tick=1, busy=1; div_out pattern 1,1,1,1,0,0,0 repeating; tick every 7 cycles; cfg_ready=1 from the first post-reset cycle.
- RUN with N=7, offer cfg_div=4 at cnt=2 -> cfg_ready=0 until the boundary; after cnt=6 the next period shows pattern 1,1,0,0; active_div=4 and cfg_ready=1 in the cycle with tick=1.
- cfg_div=1 and cfg_div=0 offered in RUN and in IDLE -> cfg_err single-cycle pulse each time; active_div unchanged; period unaffected.
- RUN N=5, en_req=0 at cnt=1 -> period completes (cnt reaches 4), then div_out=0, busy=0; second run: en_req drop at cnt=1 and re-raise at cnt=3 -> no gap, tick continues every 5 cycles.
- Pending ratio 3 plus en_req=0 hitting the same boundary -> IDLE with active_div=3; restart gives pattern 1,1,0.
- rst=1 mid-period with a pending ratio -> next cycle all outputs at reset values, active_div=DEF_DIV, pending ratio not applied after restart.
